fpu_share_arbiter: RTL



---
 rtl/fpu_share_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin arbiter and sequencer that shares one 64-bit
// FP execution unit between two clients. A bundle is captured over the
// stable/ack handshake, issued to the EU with a one-cycle start pulse, and the
// result is returned over the z_stable/z_ack handshake.
// Optional feature: define FPU_ARB_TIMEOUT_EN to bound WAIT with a watchdog
// that returns qNaN and raises a sticky err after TIMEOUT_CYCLES cycles.
module fpu_share_arbiter #(
    parameter int WIDTH          = 64,
    parameter int OP_W           = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] c0_a,
    input  logic [WIDTH-1:0] c0_b,
    input  logic [OP_W-1:0]  c0_op,
    input  logic             c0_stable,
    output logic             c0_ack,
    output logic [WIDTH-1:0] c0_z,
    output logic             c0_z_stable,
    input  logic             c0_z_ack,
    input  logic [WIDTH-1:0] c1_a,
    input  logic [WIDTH-1:0] c1_b,
    input  logic [OP_W-1:0]  c1_op,
    input  logic             c1_stable,
    output logic             c1_ack,
    output logic [WIDTH-1:0] c1_z,
    output logic             c1_z_stable,
    input  logic             c1_z_ack,
    output logic [WIDTH-1:0] eu_a,
    output logic [WIDTH-1:0] eu_b,
    output logic [OP_W-1:0]  eu_op,
    output logic             eu_start,
    input  logic [WIDTH-1:0] eu_z,
    input  logic             eu_done,
    output logic             err
);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [WIDTH-1:0] QNAN = WIDTH'(64'h7FF8_0000_0000_0000);

    // A watchdog shorter than two cycles cannot tell a slow EU from a hung one.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_gnt;
    logic             r_last;
    logic [1:0]       r_rearm;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic [WIDTH-1:0] r_result;

    logic [1:0]       w_elig;
    logic             w_pick;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OP_W-1:0]  w_sel_op;
    logic             w_legal;
    logic             w_z_ack_sel;
    logic             w_timeout;
    logic             w_drive_eu;

    assign w_elig      = {c1_stable & r_rearm[1], c0_stable & r_rearm[0]};
    assign w_sel_a     = r_gnt ? c1_a  : c0_a;
    assign w_sel_b     = r_gnt ? c1_b  : c0_b;
    assign w_sel_op    = r_gnt ? c1_op : c0_op;
    // Only add, sub, mul and div (codes 0..3) are sent to the EU.
    assign w_legal     = (w_sel_op[OP_W-1:2] == '0);
    assign w_z_ack_sel = r_gnt ? c1_z_ack : c0_z_ack;

    // Next-state and grant choice; a tie goes to the client not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_pick      = r_gnt;
        case (r_state)
            S_IDLE: begin
                if (w_elig != 2'b00) begin
                    w_state_nxt = S_GRANT;
                    w_pick      = (w_elig == 2'b11) ? ~r_last : w_elig[1];
                end
            end
            S_GRANT: w_state_nxt = w_legal ? S_ISSUE : S_RESP;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (eu_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (w_z_ack_sel) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control registers: state, granted client, round-robin history, rearm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_rearm <= 2'b11;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_pick;
            if (r_state == S_RESP && w_z_ack_sel) r_last <= r_gnt;
            // Dropping stable re-arms a client; being granted disarms it.
            r_rearm[0] <= ~c0_stable | (r_rearm[0] & ~(r_state == S_GRANT && !r_gnt));
            r_rearm[1] <= ~c1_stable | (r_rearm[1] & ~(r_state == S_GRANT &&  r_gnt));
        end
    end

    // Operand capture on the edge leaving GRANT; outputs are gated, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_GRANT) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
        end
    end

    // Result register: EU result, or qNaN for an illegal op or a watchdog expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (r_state == S_GRANT && !w_legal) begin
            r_result <= QNAN;
        end else if (r_state == S_WAIT && eu_done) begin
            r_result <= eu_z;
        end else if (w_timeout) begin
            r_result <= QNAN;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_timeout = (r_state == S_WAIT) && !eu_done && (r_tmo_cnt == TMO_LAST);
    assign err       = r_err;

    // Watchdog: counts WAIT cycles; err stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + CNT_W'(1) : '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_drive_eu  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign eu_start    = (r_state == S_ISSUE);
    assign eu_a        = w_drive_eu ? r_a  : '0;
    assign eu_b        = w_drive_eu ? r_b  : '0;
    assign eu_op       = w_drive_eu ? r_op : '0;
    assign c0_ack      = (r_state == S_GRANT) && !r_gnt;
    assign c1_ack      = (r_state == S_GRANT) &&  r_gnt;
    assign c0_z_stable = (r_state == S_RESP)  && !r_gnt;
    assign c1_z_stable = (r_state == S_RESP)  &&  r_gnt;
    assign c0_z        = c0_z_stable ? r_result : '0;
    assign c1_z        = c1_z_stable ? r_result : '0;

endmodule
